// File: rtl/alu_sequencer.sv
// alu_sequencer: single-issue IDLE/EXEC/WB controller feeding an external ALU from a small register file
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W = 4,
  parameter int NREG = 4,
  parameter int FLAG_W = 3,
  parameter int IW = $clog2(NREG),
  parameter logic [OP_W-1:0] OP_LOADI = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_opcode,
  input  logic [IW-1:0]     instr_rd,
  input  logic [IW-1:0]     instr_rs1,
  input  logic [IW-1:0]     instr_rs2,
  input  logic [DATA_W-1:0] instr_addr,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_operand_A,
  output logic [DATA_W-1:0] alu_operand_B,
  output logic [DATA_W-1:0] alu_memory_address,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flag,
  output logic              wb_valid,
  output logic [IW-1:0]     wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [FLAG_W-1:0] flags,
  output logic              busy
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2;
  logic [1:0] state;
  logic [DATA_W-1:0] regs [NREG];
  logic [FLAG_W-1:0] cap_flag;
  always_comb begin
    instr_ready = (state == IDLE) && !rst;
    busy = (state == EXEC) || (state == WB);
  end
  // wb_data doubles as the captured result, so WB writes the register file straight from it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      regs <= '{default: '0};
      cap_flag <= '0;
      flags <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      alu_opcode <= '0;
      alu_operand_A <= '0;
      alu_operand_B <= '0;
      alu_memory_address <= '0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          alu_opcode <= instr_opcode;
          alu_operand_A <= regs[instr_rs1];
          alu_operand_B <= regs[instr_rs2];
          alu_memory_address <= instr_addr;
          wb_rd <= instr_rd;
          if (instr_opcode == OP_LOADI) begin
            wb_data <= instr_addr;
            wb_valid <= 1'b1;
            state <= WB;
          end else
            state <= EXEC;
        end
        EXEC: begin
          wb_data <= alu_result;
          cap_flag <= alu_flag;
          wb_valid <= 1'b1;
          state <= WB;
        end
        WB: begin
          regs[wb_rd] <= wb_data;
          if (alu_opcode != OP_LOADI) flags <= cap_flag;
          wb_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of the sequencer against an adder ALU stub
module tb_alu_sequencer;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, instr_ready;
  logic [3:0] instr_opcode = '0, alu_opcode;
  logic [1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0, wb_rd;
  logic [7:0] instr_addr = '0, alu_operand_A, alu_operand_B, alu_memory_address, alu_result, wb_data;
  logic [2:0] alu_flag, flags;
  logic wb_valid, busy, carry;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign {carry, alu_result} = {1'b0, alu_operand_A} + {1'b0, alu_operand_B};
  assign alu_flag = {alu_result == 8'h00, carry, alu_result[7]};

  alu_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_addr(instr_addr), .alu_opcode(alu_opcode), .alu_operand_A(alu_operand_A),
    .alu_operand_B(alu_operand_B), .alu_memory_address(alu_memory_address),
    .alu_result(alu_result), .alu_flag(alu_flag), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .flags(flags), .busy(busy)
  );

  // offer one instruction from an IDLE negedge; returns at the negedge of the cycle after the handshake
  task automatic send(input logic [3:0] op, input logic [1:0] rd, rs1, rs2, input logic [7:0] addr);
    instr_opcode = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_addr = addr;
    instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %h exp %h", instr_ready, 1'b0); end
    @(negedge clk);
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %h exp %h", instr_ready, 1'b0); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %h exp %h", instr_ready, 1'b1); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %h exp %h", wb_valid, 1'b0); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL rst_flags got %h exp %h", flags, 3'b000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %h exp %h", busy, 1'b0); end
    checks++; if ({alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address, wb_data} !== 36'h0) begin errors++; $display("FAIL rst_outs got %h exp %h", {alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address, wb_data}, 36'h0); end
  endtask

  task automatic test_loadi;
    send(4'hF, 2'd1, 2'd0, 2'd0, 8'h02);
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd1, 8'h02}) begin errors++; $display("FAIL loadi1_wb got %h exp %h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd1, 8'h02}); end
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL loadi1_ready got %h exp %h", instr_ready, 1'b0); end
    @(negedge clk);
    checks++; if ({wb_valid, instr_ready} !== 2'b01) begin errors++; $display("FAIL loadi1_done got %h exp %h", {wb_valid, instr_ready}, 2'b01); end
    send(4'hF, 2'd2, 2'd0, 2'd0, 8'h27);
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd2, 8'h27}) begin errors++; $display("FAIL loadi2_wb got %h exp %h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd2, 8'h27}); end
    @(negedge clk);
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL loadi_flags got %h exp %h", flags, 3'b000); end
  endtask

  task automatic test_alu_op;
    send(4'h4, 2'd0, 2'd1, 2'd2, 8'h10);
    checks++; if ({alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address} !== {4'h4, 8'h02, 8'h27, 8'h10}) begin errors++; $display("FAIL alu_exec_outs got %h exp %h", {alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address}, {4'h4, 8'h02, 8'h27, 8'h10}); end
    checks++; if ({wb_valid, instr_ready, busy} !== 3'b001) begin errors++; $display("FAIL alu_exec_ctl got %h exp %h", {wb_valid, instr_ready, busy}, 3'b001); end
    @(negedge clk);
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd0, 8'h29}) begin errors++; $display("FAIL alu_wb got %h exp %h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd0, 8'h29}); end
    checks++; if ({instr_ready, busy} !== 2'b01) begin errors++; $display("FAIL alu_wb_ctl got %h exp %h", {instr_ready, busy}, 2'b01); end
    @(negedge clk);
    checks++; if ({wb_valid, instr_ready, flags} !== {2'b01, 3'b000}) begin errors++; $display("FAIL alu_done got %h exp %h", {wb_valid, instr_ready, flags}, {2'b01, 3'b000}); end
  endtask

  task automatic test_back_to_back;
    send(4'hF, 2'd1, 2'd0, 2'd0, 8'hFF); @(negedge clk);
    send(4'hF, 2'd2, 2'd0, 2'd0, 8'h01); @(negedge clk);
    send(4'h8, 2'd3, 2'd1, 2'd2, 8'h00);
    checks++; if ({alu_opcode, alu_operand_A, alu_operand_B} !== {4'h8, 8'hFF, 8'h01}) begin errors++; $display("FAIL carry_exec got %h exp %h", {alu_opcode, alu_operand_A, alu_operand_B}, {4'h8, 8'hFF, 8'h01}); end
    @(negedge clk);
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd3, 8'h00}) begin errors++; $display("FAIL carry_wb got %h exp %h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd3, 8'h00}); end
    @(negedge clk);
    checks++; if (flags !== 3'b110) begin errors++; $display("FAIL carry_flags got %h exp %h", flags, 3'b110); end
    send(4'h4, 2'd0, 2'd3, 2'd3, 8'h00);
    checks++; if ({alu_operand_A, alu_operand_B} !== 16'h0000) begin errors++; $display("FAIL dep_operands got %h exp %h", {alu_operand_A, alu_operand_B}, 16'h0000); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_valid_held;
    instr_opcode = 4'h4; instr_rd = 2'd0; instr_rs1 = 2'd1; instr_rs2 = 2'd2; instr_addr = 8'h55;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_opcode = 4'h2; instr_rs1 = 2'd3; instr_rs2 = 2'd3; instr_addr = 8'hAA;
    @(negedge clk);
    checks++; if ({alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address} !== {4'h4, 8'hFF, 8'h01, 8'h55}) begin errors++; $display("FAIL held_exec got %h exp %h", {alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address}, {4'h4, 8'hFF, 8'h01, 8'h55}); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL held_exec_wb got %h exp %h", wb_valid, 1'b0); end
    instr_rs1 = 2'd0; instr_addr = 8'h77;
    @(negedge clk);
    checks++; if ({alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address} !== {4'h4, 8'hFF, 8'h01, 8'h55}) begin errors++; $display("FAIL held_wb_outs got %h exp %h", {alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address}, {4'h4, 8'hFF, 8'h01, 8'h55}); end
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd0, 8'h00}) begin errors++; $display("FAIL held_wb got %h exp %h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd0, 8'h00}); end
    instr_opcode = 4'h8; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd1; instr_addr = 8'hAA;
    @(posedge clk); @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    checks++; if ({alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address} !== {4'h8, 8'hFF, 8'hFF, 8'hAA}) begin errors++; $display("FAIL held_second got %h exp %h", {alu_opcode, alu_operand_A, alu_operand_B, alu_memory_address}, {4'h8, 8'hFF, 8'hFF, 8'hAA}); end
    @(negedge clk);
    checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 2'd3, 8'hFE}) begin errors++; $display("FAIL held_second_wb got %h exp %h", {wb_valid, wb_rd, wb_data}, {1'b1, 2'd3, 8'hFE}); end
    @(negedge clk);
    checks++; if (flags !== 3'b011) begin errors++; $display("FAIL held_flags got %h exp %h", flags, 3'b011); end
  endtask

  task automatic test_reset_exec;
    send(4'h4, 2'd1, 2'd1, 2'd2, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({wb_valid, instr_ready, alu_opcode} !== 6'h0) begin errors++; $display("FAIL rstx_state got %h exp %h", {wb_valid, instr_ready, alu_opcode}, 6'h0); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({wb_valid, instr_ready, flags} !== {2'b01, 3'b000}) begin errors++; $display("FAIL rstx_after got %h exp %h", {wb_valid, instr_ready, flags}, {2'b01, 3'b000}); end
    send(4'h4, 2'd0, 2'd1, 2'd2, 8'h33);
    checks++; if ({alu_operand_A, alu_operand_B, alu_memory_address} !== {16'h0000, 8'h33}) begin errors++; $display("FAIL rstx_r1r2 got %h exp %h", {alu_operand_A, alu_operand_B, alu_memory_address}, {16'h0000, 8'h33}); end
    @(negedge clk); @(negedge clk);
    send(4'h4, 2'd0, 2'd3, 2'd0, 8'h00);
    checks++; if ({alu_operand_A, alu_operand_B} !== 16'h0000) begin errors++; $display("FAIL rstx_r3r0 got %h exp %h", {alu_operand_A, alu_operand_B}, 16'h0000); end
    @(negedge clk);
    checks++; if ({wb_valid, wb_data} !== {1'b1, 8'h00}) begin errors++; $display("FAIL rstx_wb got %h exp %h", {wb_valid, wb_data}, {1'b1, 8'h00}); end
    @(negedge clk);
    checks++; if (flags !== 3'b100) begin errors++; $display("FAIL rstx_flags got %h exp %h", flags, 3'b100); end
  endtask

  initial begin
    test_reset;
    test_loadi;
    test_alu_op;
    test_back_to_back;
    test_valid_held;
    test_reset_exec;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
